// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller.
package gcd_pkg;

    // Default operand/result width.
    localparam int GCD_W = 16;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN,
        DONE
    } gcd_state_e;

    // Width of a counter that must hold values 0..max_iter without wrapping.
    function automatic int iter_cnt_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtract-step counter: clear on accept, count steps, flag when the limit is reached.
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = 2**GCD_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic limit_hit
);

    localparam int CW = iter_cnt_width(MAX_ITER);

    logic [CW-1:0] cnt;

    assign limit_hit = (cnt == CW'(MAX_ITER));

    // Step count register; saturates at the limit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !limit_hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gcd_controller.sv
// Sequencing FSM for the subtractive GCD datapath: operand load, step issue, result return.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int W        = GCD_W,
    parameter int MAX_ITER = 2**W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic         err,
    input  logic         lt,
    input  logic         gt,
    input  logic         eq,
    input  logic [W-1:0] dp_result,
    output logic         ldA,
    output logic         ldB,
    output logic         sel1,
    output logic         sel2,
    output logic         sel_in,
    output logic [W-1:0] data_in
);

    gcd_state_e state, state_n;

    logic [W-1:0] a_q, b_q;
    logic         cnt_clr, cnt_inc, limit_hit;
    logic         accept, zero_op;

    assign accept  = (state == IDLE) && in_valid;
    assign zero_op = (a_in == '0) || (b_in == '0);

    gcd_iter_counter #(
        .MAX_ITER(MAX_ITER)
    ) u_iter_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .limit_hit(limit_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Operand capture on accept and result/error capture on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            res <= '0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= a_in;
                b_q <= b_in;
                if (zero_op) begin
                    res <= a_in | b_in;
                    err <= 1'b0;
                end
            end
            if (state == RUN) begin
                if (eq) begin
                    res <= dp_result;
                    err <= 1'b0;
                end else if (limit_hit) begin
                    res <= '0;
                    err <= 1'b1;
                end
            end
        end
    end

    // Next-state and Mealy datapath controls; eq wins over timeout, timeout over gt, gt over lt.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        sel1      = 1'b0;
        sel2      = 1'b0;
        sel_in    = 1'b0;
        data_in   = '0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_clr = 1'b1;
                    state_n = zero_op ? DONE : LOAD_A;
                end
            end
            LOAD_A: begin
                sel_in  = 1'b1;
                data_in = a_q;
                ldA     = 1'b1;
                state_n = LOAD_B;
            end
            LOAD_B: begin
                sel_in  = 1'b1;
                data_in = b_q;
                ldB     = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (eq) begin
                    state_n = DONE;
                end else if (limit_hit) begin
                    state_n = DONE;
                end else if (gt) begin
                    sel2    = 1'b1;
                    ldA     = 1'b1;
                    cnt_inc = 1'b1;
                end else if (lt) begin
                    sel1    = 1'b1;
                    ldB     = 1'b1;
                    cnt_inc = 1'b1;
                end else begin
                    // No flag at all: load nothing but still count, so the timeout bounds the stall.
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench for gcd_controller: two instances (default and short timeout) each driving a behavioural datapath.
module tb_gcd_controller;
    import gcd_pkg::*;

    localparam int W      = GCD_W;
    localparam int MAXIT0 = 2**W;
    localparam int MAXIT1 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] a_in, b_in;
    logic [1:0]   iv, ir, ov, ordy, erro, lda, ldb, s1, s2, sin, flt, fgt, feq;
    logic [W-1:0] res0, res1, din0, din1, ra0, rb0, ra1, rb1;

    gcd_controller u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a_in(a_in), .b_in(b_in), .out_valid(ov[0]), .out_ready(ordy[0]),
        .res(res0), .err(erro[0]), .lt(flt[0]), .gt(fgt[0]), .eq(feq[0]),
        .dp_result(ra0), .ldA(lda[0]), .ldB(ldb[0]), .sel1(s1[0]), .sel2(s2[0]),
        .sel_in(sin[0]), .data_in(din0)
    );

    gcd_controller #(.W(W), .MAX_ITER(MAXIT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a_in(a_in), .b_in(b_in), .out_valid(ov[1]), .out_ready(ordy[1]),
        .res(res1), .err(erro[1]), .lt(flt[1]), .gt(fgt[1]), .eq(feq[1]),
        .dp_result(ra1), .ldA(lda[1]), .ldB(ldb[1]), .sel1(s1[1]), .sel2(s2[1]),
        .sel_in(sin[1]), .data_in(din1)
    );

    // Datapath comparator flags.
    assign flt[0] = ra0 < rb0;
    assign fgt[0] = ra0 > rb0;
    assign feq[0] = ra0 == rb0;
    assign flt[1] = ra1 < rb1;
    assign fgt[1] = ra1 > rb1;
    assign feq[1] = ra1 == rb1;

    // Datapath registers for instance 0: X/Y muxes, subtractor, input bus.
    always @(posedge clk) begin : dp0
        logic [W-1:0] x, y, bus;
        x   = s1[0] ? rb0 : ra0;
        y   = s2[0] ? rb0 : ra0;
        bus = sin[0] ? din0 : (x - y);
        if (lda[0]) ra0 <= bus;
        if (ldb[0]) rb0 <= bus;
    end

    // Datapath registers for instance 1.
    always @(posedge clk) begin : dp1
        logic [W-1:0] x, y, bus;
        x   = s1[1] ? rb1 : ra1;
        y   = s2[1] ? rb1 : ra1;
        bus = sin[1] ? din1 : (x - y);
        if (lda[1]) ra1 <= bus;
        if (ldb[1]) rb1 <= bus;
    end

    // View of the instance currently under test.
    int cur = 0;
    logic [W-1:0] cres, cdin;
    logic         cir, cov, cerr, clda, cldb, csin;
    always_comb begin
        cres = (cur == 1) ? res1 : res0;
        cdin = (cur == 1) ? din1 : din0;
        cir  = ir[cur];
        cov  = ov[cur];
        cerr = erro[cur];
        clda = lda[cur];
        cldb = ldb[cur];
        csin = sin[cur];
    end

    // Reference: gcd and number of subtract steps from plain arithmetic; steps = -1 for the zero-operand path.
    function automatic void ref_model(input int a, input int b, output int g, output int steps);
        int x, y;
        x = a;
        y = b;
        steps = 0;
        if (x == 0 || y == 0) begin
            g = x | y;
            steps = -1;
            return;
        end
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
            steps++;
        end
        g = x;
    endfunction

    task automatic run_op(input int k, input int a, input int b, input int hold, input string name);
        int g, steps, maxit, exp_cyc, exp_res, cyc, budget;
        logic exp_err, bad_ready;
        logic [W-1:0] held;
        cur = k;
        maxit = (k == 1) ? MAXIT1 : MAXIT0;
        ref_model(a, b, g, steps);
        if (steps < 0) begin
            exp_cyc = 1; exp_res = g; exp_err = 1'b0;
        end else if (steps > maxit) begin
            exp_cyc = maxit + 4; exp_res = 0; exp_err = 1'b1;
        end else begin
            exp_cyc = steps + 4; exp_res = g; exp_err = 1'b0;
        end
        budget = exp_cyc + 20;
        bad_ready = 1'b0;

        @(negedge clk);
        checks++;
        if (cir !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready: got %b expected 1", name, cir);
        end
        a_in = W'(a);
        b_in = W'(b);
        iv[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0;
        cyc = 1;
        while (cov !== 1'b1 && cyc < budget) begin
            if (cir !== 1'b0) bad_ready = 1'b1;
            if (steps >= 0 && cyc == 1) begin
                checks++;
                if (clda !== 1'b1 || cldb !== 1'b0 || csin !== 1'b1 || cdin !== W'(a)) begin
                    failures++;
                    $display("FAIL %s load_a: ldA=%b ldB=%b sel_in=%b data_in=%0d expected 1 0 1 %0d",
                             name, clda, cldb, csin, cdin, a);
                end
            end
            if (steps >= 0 && cyc == 2) begin
                checks++;
                if (cldb !== 1'b1 || clda !== 1'b0 || csin !== 1'b1 || cdin !== W'(b)) begin
                    failures++;
                    $display("FAIL %s load_b: ldA=%b ldB=%b sel_in=%b data_in=%0d expected 0 1 1 %0d",
                             name, clda, cldb, csin, cdin, b);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cov !== 1'b1) begin
            failures++;
            $display("FAIL %s out_valid_timeout: no out_valid within %0d cycles", name, budget);
        end
        checks++;
        if (cyc != exp_cyc) begin
            failures++;
            $display("FAIL %s latency: got cycle %0d expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (cres !== W'(exp_res) || cerr !== exp_err) begin
            failures++;
            $display("FAIL %s result: res=%0d err=%b expected res=%0d err=%b", name, cres, cerr, exp_res, exp_err);
        end
        checks++;
        if (bad_ready || cir !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_ready: in_ready high while busy, expected 0", name);
        end
        held = cres;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (cov !== 1'b1 || cres !== held || cerr !== exp_err || cir !== 1'b0) begin
                failures++;
                $display("FAIL %s hold: out_valid=%b res=%0d err=%b in_ready=%b expected 1 %0d %b 0",
                         name, cov, cres, cerr, cir, held, exp_err);
            end
        end
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        checks++;
        if (cir !== 1'b1 || cov !== 1'b0) begin
            failures++;
            $display("FAIL %s release: in_ready=%b out_valid=%b expected 1 0", name, cir, cov);
        end
    endtask

    task automatic check_reset_outputs(input int k, input string name);
        cur = k;
        #1;
        checks++;
        if (cir !== 1'b1 || cov !== 1'b0 || cres !== '0 || cerr !== 1'b0 || clda !== 1'b0 ||
            cldb !== 1'b0 || s1[k] !== 1'b0 || s2[k] !== 1'b0 || csin !== 1'b0 || cdin !== '0) begin
            failures++;
            $display("FAIL %s: in_ready=%b out_valid=%b res=%0d err=%b ldA=%b ldB=%b sel1=%b sel2=%b sel_in=%b data_in=%0d expected 1 0 0 0 0 0 0 0 0 0",
                     name, cir, cov, cres, cerr, clda, cldb, s1[k], s2[k], csin, cdin);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs(0, "reset_dut0");
        check_reset_outputs(1, "reset_dut1");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(0, 12, 8, 0, "gcd_12_8");
        run_op(0, 7, 7, 0, "gcd_7_7");
        run_op(0, 0, 9, 0, "gcd_0_9");
        run_op(0, 0, 0, 0, "gcd_0_0");
        run_op(0, 48, 18, 5, "gcd_48_18_hold");
    endtask

    task automatic test_timeout();
        run_op(1, 100, 1, 0, "timeout_100_1");
        run_op(1, 12, 8, 2, "short_12_8");
        run_op(1, 9, 1, 0, "limit_exact_9_1");
        run_op(1, 10, 1, 0, "limit_over_10_1");
    endtask

    task automatic test_random();
        int a, b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(300, 1);
            b = $urandom_range(300, 1);
            if (i == 5) a = 0;
            run_op(0, a, b, $urandom_range(2, 0), "random_dut0");
        end
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(40, 1);
            b = $urandom_range(40, 1);
            run_op(1, a, b, 0, "random_dut1");
        end
    endtask

    task automatic test_reset_mid_run();
        cur = 0;
        @(negedge clk);
        a_in = 16'hFFFF;
        b_in = 16'd1;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (clda !== 1'b1 || cov !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_active: ldA=%b out_valid=%b expected 1 0", clda, cov);
        end
        #2;
        rst_n = 1'b0;
        check_reset_outputs(0, "reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 21, 14, 0, "after_reset_21_14");
    endtask

    task automatic test_long();
        run_op(0, 65535, 1, 0, "long_65535_1");
    endtask

    initial begin
        iv = '0;
        ordy = '0;
        a_in = '0;
        b_in = '0;
        test_reset();
        test_directed();
        test_timeout();
        test_random();
        test_reset_mid_run();
        test_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
